// File: rtl/ttt_game_ctrl_if.sv
// rtl/ttt_game_ctrl_if.sv - mouse/menu inputs and board-state outputs of the tic-tac-toe controller
interface ttt_game_ctrl_if;
  logic        start_en;
  logic        new_game;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        mouse_left;
  logic [8:0]  cell_occ;
  logic [8:0]  cell_owner;
  logic        turn;
  logic [1:0]  winner;
  logic [8:0]  win_mask;
  logic        game_over;
  logic        move_pulse;
  logic        illegal_pulse;
  logic        timeout_pulse;

  modport slave (
    input  start_en, new_game, xpos, ypos, mouse_left,
    output cell_occ, cell_owner, turn, winner, win_mask, game_over,
           move_pulse, illegal_pulse, timeout_pulse
  );

  modport master (
    output start_en, new_game, xpos, ypos, mouse_left,
    input  cell_occ, cell_owner, turn, winner, win_mask, game_over,
           move_pulse, illegal_pulse, timeout_pulse
  );
endinterface

// File: rtl/ttt_game_ctrl.sv
// rtl/ttt_game_ctrl.sv - tic-tac-toe turn/board controller; MOVE_TIMEOUT_EN adds per-move forfeit timer
module ttt_game_ctrl #(
  parameter bit          FIRST_PLAYER   = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 650000000
) (
  input  logic pclk,
  input  logic rst,
  ttt_game_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, ARM, WAIT_PRESS, CHECK, WAIT_RELEASE, OVER
  } state_t;

  // Line order sets win_mask priority when two lines complete together
  localparam logic [8:0] LINES [8] = '{
    9'h007, 9'h038, 9'h1C0, 9'h049, 9'h092, 9'h124, 9'h111, 9'h054
  };

  state_t     state_q, state_d;
  logic       mouse_q;
  logic [8:0] occ_q, occ_d;
  logic [8:0] owner_q, owner_d;
  logic       turn_q, turn_d;
  logic [1:0] winner_q, winner_d;
  logic [8:0] mask_q, mask_d;
  logic       move_q, move_d;
  logic       ill_q, ill_d;
  logic       to_q, to_d;

  logic       press;
  logic [1:0] col_idx, row_idx;
  logic       col_hit, row_hit, hit;
  logic [3:0] hit_idx;
  logic [8:0] mine;
  logic       win_found;
  logic [8:0] win_line;

  assign press = bus.mouse_left & ~mouse_q;

  always_comb begin
    col_hit = 1'b1;
    col_idx = 2'd0;
    if (bus.xpos <= 12'd338)                              col_idx = 2'd0;
    else if (bus.xpos >= 12'd344 && bus.xpos <= 12'd679)  col_idx = 2'd1;
    else if (bus.xpos >= 12'd685 && bus.xpos <= 12'd1023) col_idx = 2'd2;
    else                                                  col_hit = 1'b0;
    row_hit = 1'b1;
    row_idx = 2'd0;
    if (bus.ypos <= 12'd251)                              row_idx = 2'd0;
    else if (bus.ypos >= 12'd259 && bus.ypos <= 12'd507)  row_idx = 2'd1;
    else if (bus.ypos >= 12'd515 && bus.ypos <= 12'd767)  row_idx = 2'd2;
    else                                                  row_hit = 1'b0;
    hit     = col_hit & row_hit;
    hit_idx = 4'(row_idx) * 4'd3 + 4'(col_idx);
  end

  // Cells owned by the player who just moved (turn has not toggled yet in CHECK)
  assign mine = occ_q & (turn_q ? owner_q : ~owner_q);

  always_comb begin
    win_found = 1'b0;
    win_line  = 9'h000;
    for (int i = 7; i >= 0; i--) begin
      if ((mine & LINES[i]) == LINES[i]) begin
        win_found = 1'b1;
        win_line  = LINES[i];
      end
    end
  end

`ifdef MOVE_TIMEOUT_EN
  logic [29:0] cnt_q, cnt_d;
  logic        running, expire, move_now;

  assign running  = bus.start_en &&
                    (state_q == ARM || state_q == WAIT_PRESS || state_q == WAIT_RELEASE);
  assign move_now = (state_q == WAIT_PRESS) && press;
  assign expire   = running && (cnt_q == 30'(TIMEOUT_CYCLES - 1));

  // Counter only lives in the waiting states, so CHECK (after a move) and IDLE clear it
  always_comb begin
    cnt_d = 30'd0;
    if (running && !bus.new_game && !expire && !move_now)
      cnt_d = cnt_q + 30'd1;
  end

  always_ff @(posedge pclk) begin
    if (rst) cnt_q <= 30'd0;
    else     cnt_q <= cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d  = state_q;
    occ_d    = occ_q;
    owner_d  = owner_q;
    turn_d   = turn_q;
    winner_d = winner_q;
    mask_d   = mask_q;
    move_d   = 1'b0;
    ill_d    = 1'b0;
    to_d     = 1'b0;
    if (bus.new_game) begin
      occ_d    = 9'h000;
      owner_d  = 9'h000;
      turn_d   = FIRST_PLAYER;
      winner_d = 2'b00;
      mask_d   = 9'h000;
      state_d  = bus.start_en ? ARM : IDLE;
    end else begin
      case (state_q)
        IDLE: if (bus.start_en) state_d = ARM;
        ARM: begin
          if (!bus.start_en)        state_d = IDLE;
          else if (!bus.mouse_left) state_d = WAIT_PRESS;
        end
        WAIT_PRESS: begin
          if (!bus.start_en) state_d = IDLE;
          else if (press) begin
            if (hit && !occ_q[hit_idx]) begin
              occ_d[hit_idx]   = 1'b1;
              owner_d[hit_idx] = turn_q;
              move_d           = 1'b1;
              state_d          = CHECK;
            end else begin
              ill_d   = 1'b1;
              state_d = WAIT_RELEASE;
            end
          end
        end
        CHECK: begin
          if (win_found) begin
            winner_d = turn_q ? 2'b10 : 2'b01;
            mask_d   = win_line;
            state_d  = OVER;
          end else if (&occ_q) begin
            winner_d = 2'b11;
            state_d  = OVER;
          end else begin
            turn_d  = ~turn_q;
            state_d = bus.start_en ? WAIT_RELEASE : IDLE;
          end
        end
        WAIT_RELEASE: begin
          if (!bus.start_en)        state_d = IDLE;
          else if (!bus.mouse_left) state_d = WAIT_PRESS;
        end
        OVER:    state_d = OVER;
        default: state_d = IDLE;
      endcase
`ifdef MOVE_TIMEOUT_EN
      // A press landing on the expiry cycle wins over the forfeit
      if (expire && !move_now) begin
        turn_d = ~turn_q;
        to_d   = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q  <= IDLE;
      mouse_q  <= 1'b0;
      occ_q    <= 9'h000;
      owner_q  <= 9'h000;
      turn_q   <= FIRST_PLAYER;
      winner_q <= 2'b00;
      mask_q   <= 9'h000;
      move_q   <= 1'b0;
      ill_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      mouse_q  <= bus.mouse_left;
      occ_q    <= occ_d;
      owner_q  <= owner_d;
      turn_q   <= turn_d;
      winner_q <= winner_d;
      mask_q   <= mask_d;
      move_q   <= move_d;
      ill_q    <= ill_d;
      to_q     <= to_d;
    end
  end

  assign bus.cell_occ      = occ_q;
  assign bus.cell_owner    = owner_q;
  assign bus.turn          = turn_q;
  assign bus.winner        = winner_q;
  assign bus.win_mask      = mask_q;
  assign bus.game_over     = (state_q == OVER);
  assign bus.move_pulse    = move_q;
  assign bus.illegal_pulse = ill_q;
  assign bus.timeout_pulse = to_q;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// tb/tb_ttt_game_ctrl.sv - directed self-checking bench for ttt_game_ctrl
module tb_ttt_game_ctrl;
  logic pclk = 1'b0;
  logic rst  = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic mp, ip, tn1;
  logic [8:0] occ_n1;

  localparam int COLX [3] = '{100, 500, 900};
  localparam int ROWY [3] = '{100, 400, 700};

  ttt_game_ctrl_if bus ();

  ttt_game_ctrl #(.FIRST_PLAYER(1'b0), .TIMEOUT_CYCLES(16)) dut (
    .pclk(pclk), .rst(rst), .bus(bus)
  );

  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // One press/release; captures pulses, board and turn one cycle after the press
  task automatic click(input int x, input int y);
    bus.xpos = 12'(x);
    bus.ypos = 12'(y);
    bus.mouse_left = 1'b1;
    tick();
    mp = bus.move_pulse;
    ip = bus.illegal_pulse;
    occ_n1 = bus.cell_occ;
    tn1 = bus.turn;
    bus.mouse_left = 1'b0;
    tick();
    tick();
  endtask

  task automatic click_cell(input int c);
    click(COLX[c % 3], ROWY[c / 3]);
  endtask

  task automatic play(input int seq [9], input int n);
    for (int i = 0; i < n; i++) click_cell(seq[i]);
  endtask

  task automatic start_new();
    bus.start_en = 1'b1;
    bus.mouse_left = 1'b0;
    bus.new_game = 1'b1;
    tick();
    bus.new_game = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    bus.start_en = 1'b0; bus.new_game = 1'b0; bus.mouse_left = 1'b0;
    bus.xpos = 12'd0; bus.ypos = 12'd0;
    rst = 1'b1;
    tick(); tick();
    n_checks++;
    if ({bus.cell_occ, bus.cell_owner, bus.win_mask, bus.winner, bus.turn, bus.game_over,
         bus.move_pulse, bus.illegal_pulse, bus.timeout_pulse} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got occ=%h own=%h mask=%h win=%b turn=%b", bus.cell_occ,
               bus.cell_owner, bus.win_mask, bus.winner, bus.turn);
    end
    rst = 1'b0;
  endtask

  task automatic test_held_button();
    logic any_move = 1'b0;
    bus.start_en = 1'b1;
    bus.mouse_left = 1'b1;
    bus.xpos = 12'd100; bus.ypos = 12'd100;
    for (int i = 0; i < 5; i++) begin
      tick();
      any_move |= bus.move_pulse;
    end
    n_checks++;
    if (any_move !== 1'b0 || bus.cell_occ !== 9'h000) begin
      n_fail++;
      $display("FAIL held_button move=%b occ=%h exp 0/000", any_move, bus.cell_occ);
    end
    bus.mouse_left = 1'b0;
    tick();
    click(100, 100);
    n_checks++;
    if (mp !== 1'b1 || occ_n1 !== 9'h001) begin
      n_fail++; $display("FAIL first_move mp=%b occ=%h exp 1/001", mp, occ_n1);
    end
    n_checks++;
    if (tn1 !== 1'b0 || bus.turn !== 1'b1) begin
      n_fail++; $display("FAIL turn_latency n1=%b n2=%b exp 0/1", tn1, bus.turn);
    end
    n_checks++;
    if (bus.cell_owner !== 9'h000) begin
      n_fail++; $display("FAIL first_owner got %h exp 000", bus.cell_owner);
    end
  endtask

  task automatic test_illegal();
    int xs [4] = '{100, 340, 100, 1100};
    int ys [4] = '{100, 100, 255, 100};
    for (int i = 0; i < 4; i++) begin
      click(xs[i], ys[i]);
      n_checks++;
      if (ip !== 1'b1 || mp !== 1'b0 || bus.cell_occ !== 9'h001 || bus.turn !== 1'b1) begin
        n_fail++;
        $display("FAIL illegal_%0d ip=%b mp=%b occ=%h turn=%b exp 1/0/001/1", i, ip, mp,
                 bus.cell_occ, bus.turn);
      end
    end
  endtask

  task automatic test_boundaries();
    start_new();
    click(344, 259);
    n_checks++;
    if (mp !== 1'b1 || bus.cell_occ !== 9'h010) begin
      n_fail++; $display("FAIL edge_cell4 mp=%b occ=%h exp 1/010", mp, bus.cell_occ);
    end
    click(1023, 767);
    n_checks++;
    if (bus.cell_occ !== 9'h110 || bus.cell_owner !== 9'h100) begin
      n_fail++; $display("FAIL edge_cell8 occ=%h own=%h exp 110/100", bus.cell_occ, bus.cell_owner);
    end
    click(339, 0);
    n_checks++;
    if (ip !== 1'b1) begin
      n_fail++; $display("FAIL edge_xgap ip=%b exp 1", ip);
    end
    click(0, 768);
    n_checks++;
    if (ip !== 1'b1 || bus.cell_occ !== 9'h110) begin
      n_fail++; $display("FAIL edge_yrange ip=%b occ=%h exp 1/110", ip, bus.cell_occ);
    end
  endtask

  task automatic test_win_and_new_game();
    int seq [9] = '{0, 1, 4, 2, 8, 0, 0, 0, 0};
    start_new();
    play(seq, 5);
    n_checks++;
    if (bus.winner !== 2'b01 || bus.win_mask !== 9'h111 || bus.game_over !== 1'b1) begin
      n_fail++;
      $display("FAIL diag_win win=%b mask=%h over=%b exp 01/111/1", bus.winner, bus.win_mask,
               bus.game_over);
    end
    click_cell(3);
    n_checks++;
    if (mp !== 1'b0 || ip !== 1'b0 || bus.cell_occ !== 9'h117 || bus.cell_owner !== 9'h006) begin
      n_fail++;
      $display("FAIL over_ignores mp=%b ip=%b occ=%h own=%h exp 0/0/117/006", mp, ip,
               bus.cell_occ, bus.cell_owner);
    end
    start_new();
    n_checks++;
    if ({bus.cell_occ, bus.cell_owner, bus.win_mask, bus.winner, bus.turn, bus.game_over} !== 31'd0) begin
      n_fail++;
      $display("FAIL new_game_clear occ=%h win=%b turn=%b over=%b", bus.cell_occ, bus.winner,
               bus.turn, bus.game_over);
    end
  endtask

  task automatic test_draw_and_ninth_win();
    int draw_seq [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    int win_seq  [9] = '{1, 4, 2, 5, 3, 7, 6, 8, 0};
    start_new();
    play(draw_seq, 9);
    n_checks++;
    if (bus.winner !== 2'b11 || bus.win_mask !== 9'h000 || bus.game_over !== 1'b1 ||
        bus.cell_occ !== 9'h1FF || bus.cell_owner !== 9'h072) begin
      n_fail++;
      $display("FAIL draw win=%b mask=%h over=%b occ=%h own=%h exp 11/000/1/1ff/072", bus.winner,
               bus.win_mask, bus.game_over, bus.cell_occ, bus.cell_owner);
    end
    start_new();
    play(win_seq, 9);
    n_checks++;
    if (bus.winner !== 2'b01 || bus.win_mask !== 9'h007 || bus.game_over !== 1'b1) begin
      n_fail++;
      $display("FAIL ninth_double_win win=%b mask=%h over=%b exp 01/007/1", bus.winner,
               bus.win_mask, bus.game_over);
    end
  endtask

  task automatic test_new_game_priority();
    start_new();
    bus.xpos = 12'd100; bus.ypos = 12'd100;
    bus.new_game = 1'b1;
    bus.mouse_left = 1'b1;
    tick();
    n_checks++;
    if (bus.move_pulse !== 1'b0 || bus.cell_occ !== 9'h000) begin
      n_fail++;
      $display("FAIL new_game_priority mp=%b occ=%h exp 0/000", bus.move_pulse, bus.cell_occ);
    end
    bus.new_game = 1'b0;
    bus.mouse_left = 1'b0;
    tick();
  endtask

  task automatic test_freeze();
    start_new();
    click_cell(0);
    bus.start_en = 1'b0;
    tick();
    bus.xpos = 12'd500; bus.ypos = 12'd400;
    bus.mouse_left = 1'b1;
    tick();
    n_checks++;
    if (bus.move_pulse !== 1'b0 || bus.illegal_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL frozen_click mp=%b ip=%b exp 0/0", bus.move_pulse, bus.illegal_pulse);
    end
    bus.mouse_left = 1'b0;
    tick();
    bus.start_en = 1'b1;
    tick(); tick();
    click_cell(4);
    n_checks++;
    if (mp !== 1'b1 || bus.cell_occ !== 9'h011 || bus.cell_owner !== 9'h010 || bus.turn !== 1'b0) begin
      n_fail++;
      $display("FAIL resume mp=%b occ=%h own=%h turn=%b exp 1/011/010/0", mp, bus.cell_occ,
               bus.cell_owner, bus.turn);
    end
  endtask

  task automatic test_mid_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (bus.cell_occ !== 9'h000 || bus.cell_owner !== 9'h000 || bus.turn !== 1'b0 ||
        bus.game_over !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset occ=%h own=%h turn=%b exp 000/000/0", bus.cell_occ,
               bus.cell_owner, bus.turn);
    end
  endtask

  task automatic test_timeout();
    logic any_to = 1'b0;
`ifdef MOVE_TIMEOUT_EN
    bus.start_en = 1'b1;
    bus.mouse_left = 1'b0;
    bus.new_game = 1'b1;
    tick();
    bus.new_game = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      any_to |= bus.timeout_pulse;
    end
    bus.xpos = 12'd100; bus.ypos = 12'd100;
    bus.mouse_left = 1'b1;
    tick();
    n_checks++;
    if (any_to !== 1'b0 || bus.move_pulse !== 1'b1 || bus.timeout_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL press_on_expiry early=%b mp=%b to=%b exp 0/1/0", any_to, bus.move_pulse,
               bus.timeout_pulse);
    end
    bus.mouse_left = 1'b0;
    tick();
    any_to = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      any_to |= bus.timeout_pulse;
    end
    tick();
    n_checks++;
    if (any_to !== 1'b0 || bus.timeout_pulse !== 1'b1 || bus.turn !== 1'b0 ||
        bus.cell_occ !== 9'h001) begin
      n_fail++;
      $display("FAIL timeout_expiry early=%b to=%b turn=%b occ=%h exp 0/1/0/001", any_to,
               bus.timeout_pulse, bus.turn, bus.cell_occ);
    end
`else
    start_new();
    for (int i = 0; i < 40; i++) begin
      tick();
      any_to |= bus.timeout_pulse;
    end
    n_checks++;
    if (any_to !== 1'b0 || bus.turn !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_disabled to=%b turn=%b exp 0/0", any_to, bus.turn);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_held_button();
    test_illegal();
    test_boundaries();
    test_win_and_new_game();
    test_draw_and_ninth_win();
    test_new_game_priority();
    test_freeze();
    test_mid_reset();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
